// File: rtl/data_memory_if.sv
// Block-transfer bus between the data cache (master) and data_memory (slave).
// Request/stall contract: the master raises read or write with address/writedata
// and keeps them stable while busywait is high in the request cycle; the slave
// latches the request on that edge, holds busywait high until service ends, and
// drops busywait for exactly one cycle in which readdata is valid.
interface data_memory_if;
  logic         read;
  logic         write;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/data_memory.sv
// Multi-cycle 128-bit block memory behind the data cache: IDLE -> BUSY (LATENCY
// cycles) -> DONE (one non-stalled cycle), with fully resettable storage.
module data_memory #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic         clock,
  input  logic         reset,
  data_memory_if.slave bus,
  output logic [1:0]   dbg_state_o
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              count_q;
  logic                    op_write_q;
  logic [INDEX_BITS-1:0]   index_q;
  logic [127:0]            wdata_q;
  logic [127:0]            rdata_q;
  logic [127:0]            mem_q [DEPTH];

  // Upper block-address bits alias onto the same entries by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[27:INDEX_BITS];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_write_q <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.read || bus.write) begin
            // Read wins when both are raised; the write is simply dropped.
            op_write_q <= bus.write && !bus.read;
            index_q    <= bus.address[INDEX_BITS-1:0];
            wdata_q    <= bus.writedata;
            count_q    <= 4'(LATENCY - 1);
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (count_q == '0) begin
            if (op_write_q) begin
              mem_q[index_q] <= wdata_q;
            end else begin
              rdata_q <= mem_q[index_q];
            end
            state_q <= DONE;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the cache freezes in its request cycle.
  always_comb begin
    bus.busywait = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    bus.busywait = bus.read || bus.write;
        BUSY:    bus.busywait = 1'b1;
        default: bus.busywait = 1'b0;
      endcase
    end
  end

  assign bus.readdata = rdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: LATENCY=5 and LATENCY=1 instances checked every
// cycle against a transaction-level model plus literal expectations.
module tb_data_memory;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Per-instance drive registers; index 0 is LATENCY=5, index 1 is LATENCY=1.
  logic         rd_r [2];
  logic         wr_r [2];
  logic [27:0]  addr_r [2];
  logic [127:0] wd_r [2];
  logic         busy [2];
  logic [127:0] rdata [2];
  logic [1:0]   st0, st1;

  data_memory_if if0 ();
  data_memory_if if1 ();

  assign if0.read      = rd_r[0];
  assign if0.write     = wr_r[0];
  assign if0.address   = addr_r[0];
  assign if0.writedata = wd_r[0];
  assign if1.read      = rd_r[1];
  assign if1.write     = wr_r[1];
  assign if1.address   = addr_r[1];
  assign if1.writedata = wd_r[1];
  assign busy[0]  = if0.busywait;
  assign busy[1]  = if1.busywait;
  assign rdata[0] = if0.readdata;
  assign rdata[1] = if1.readdata;

  data_memory #(.LATENCY(5), .INDEX_BITS(6)) u_dut0 (
    .clock(clk), .reset(rst), .bus(if0), .dbg_state_o(st0)
  );

  data_memory #(.LATENCY(1), .INDEX_BITS(6)) u_dut1 (
    .clock(clk), .reset(rst), .bus(if1), .dbg_state_o(st1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: an access accepted at edge c completes at edge
  // c+LATENCY, shows one non-stalled cycle, then the block is idle again.
  int           lat [2] = '{5, 1};
  longint       cyc = 0;
  logic [127:0] mem_m [2][64];
  logic [127:0] rd_m [2];
  bit           pend [2];
  bit           done_w [2];
  longint       due [2];
  bit           op_wr [2];
  logic [5:0]   idx_m [2];
  logic [127:0] wd_m [2];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
        rd_m[k]   = '0;
        pend[k]   = 0;
        done_w[k] = 0;
      end else if (done_w[k]) begin
        done_w[k] = 0;
      end else if (pend[k]) begin
        if (cyc == due[k]) begin
          pend[k]   = 0;
          done_w[k] = 1;
          if (op_wr[k]) mem_m[k][idx_m[k]] = wd_m[k];
          else          rd_m[k] = mem_m[k][idx_m[k]];
        end
      end else if (rd_r[k] || wr_r[k]) begin
        pend[k]  = 1;
        due[k]   = cyc + lat[k];
        op_wr[k] = wr_r[k] && !rd_r[k];
        idx_m[k] = addr_r[k][5:0];
        wd_m[k]  = wd_r[k];
      end
    end
  end

  function automatic logic exp_busy(input int k);
    if (rst)       return 1'b0;
    if (pend[k])   return 1'b1;
    if (done_w[k]) return 1'b0;
    return rd_r[k] || wr_r[k];
  endfunction

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busywait[%0d] cyc%0d", k, cyc), {127'd0, busy[k]}, {127'd0, exp_busy(k)});
        chk($sformatf("readdata[%0d] cyc%0d", k, cyc), rdata[k], rd_m[k]);
      end
    end
  end

  // Driver: one access with garbage on the inputs during the first BUSY cycle.
  // Returns at the falling edge of the DONE cycle so the next access is back-to-back.
  task automatic access(input int k, input logic r, input logic w,
                        input logic [27:0] a, input logic [127:0] d,
                        output int busy_cycles, output logic [127:0] rd_done);
    bit done;
    busy_cycles = 0;
    rd_done     = 'x;
    done        = 0;
    @(posedge clk); #1;
    rd_r[k] = r; wr_r[k] = w; addr_r[k] = a; wd_r[k] = d;
    @(negedge clk);
    if (busy[k]) busy_cycles++;
    @(posedge clk); #1;
    rd_r[k] = 1'b1; wr_r[k] = 1'b1; addr_r[k] = ~a; wd_r[k] = ~d;
    @(negedge clk);
    if (busy[k]) busy_cycles++;
    @(posedge clk); #1;
    rd_r[k] = 1'b0; wr_r[k] = 1'b0; addr_r[k] = '0; wd_r[k] = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy[k]) busy_cycles++;
      else begin
        rd_done = rdata[k];
        done    = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout[%0d]: busywait still high after 40 cycles, expected low", k);
    end
  endtask

  localparam logic [127:0] PAT_A = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [127:0] PAT_B = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [127:0] PAT_C = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] ONES  = {128{1'b1}};

  initial begin
    int nb;
    logic [127:0] rv;
    for (int k = 0; k < 2; k++) begin
      rd_r[k] = 0; wr_r[k] = 0; addr_r[k] = '0; wd_r[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_r[0] = 1'b1;
    @(negedge clk);
    chk("busy_during_reset", {127'd0, busy[0]}, 128'd0);
    @(posedge clk); #1;
    rd_r[0] = 1'b0;
    rst     = 1'b0;
    started = 1;
    @(negedge clk);
    chk("reset_readdata", rdata[0], 128'h0);
    chk("reset_state", {126'd0, st0}, 128'd0);

    // First read after reset: 1 + 5 stall cycles, data zero
    access(0, 1'b1, 1'b0, 28'h0000003, '0, nb, rv);
    chk("read_after_reset_busy", 128'(nb), 128'd6);
    chk("read_after_reset_data", rv, 128'h0);

    // Write then read same index, back-to-back
    access(0, 1'b0, 1'b1, 28'h0000005, PAT_A, nb, rv);
    chk("write5_busy", 128'(nb), 128'd6);
    chk("write_keeps_readdata", rv, 128'h0);
    access(0, 1'b1, 1'b0, 28'h0000005, '0, nb, rv);
    chk("read5_data", rv, PAT_A);

    // Aliased write through upper address bits
    access(0, 1'b0, 1'b1, 28'h0000045, PAT_B, nb, rv);
    access(0, 1'b1, 1'b0, 28'h0000005, '0, nb, rv);
    chk("alias_read5", rv, PAT_B);

    // Read and write together: read wins, write dropped
    access(0, 1'b1, 1'b1, 28'h0000007, ONES, nb, rv);
    chk("rw_both_data", rv, 128'h0);
    access(0, 1'b1, 1'b0, 28'h0000007, '0, nb, rv);
    chk("rw_both_no_write", rv, 128'h0);

    // Reset during the 3rd BUSY cycle aborts a pending write
    @(posedge clk); #1;
    wr_r[0] = 1'b1; addr_r[0] = 28'h0000009; wd_r[0] = PAT_C;
    @(posedge clk); #1;
    wr_r[0] = 1'b0; addr_r[0] = '0; wd_r[0] = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("busy_low_in_reset", {127'd0, busy[0]}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state_idle", {126'd0, st0}, 128'd0);
    chk("abort_busy_low", {127'd0, busy[0]}, 128'd0);
    chk("abort_readdata_cleared", rdata[0], 128'h0);
    access(0, 1'b1, 1'b0, 28'h0000009, '0, nb, rv);
    chk("abort_no_commit", rv, 128'h0);

    // Reset in DONE after a committed write still clears the entry
    access(0, 1'b0, 1'b1, 28'h000000A, PAT_C, nb, rv);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 28'h000000A, '0, nb, rv);
    chk("done_reset_clears", rv, 128'h0);

    // LATENCY=1 instance
    access(1, 1'b0, 1'b1, 28'h0000002, PAT_C, nb, rv);
    chk("lat1_write_busy", 128'(nb), 128'd2);
    access(1, 1'b1, 1'b0, 28'h0000002, '0, nb, rv);
    chk("lat1_read_busy", 128'(nb), 128'd2);
    chk("lat1_read_data", rv, PAT_C);

    // Idle cycles leave readdata alone
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat1_readdata_hold", rdata[1], PAT_C);
    chk("lat5_readdata_hold", rdata[0], 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
